xnor_cmp_sched: RTL and testbench
=================================

# xnor_cmp_sched

Two-requester scheduler that shares one bit-serial XNOR equality engine. Each requester presents a pair of W-bit operands. The block arbitrates round-robin, captures the winner's operands, and streams them LSB-first through a single XNOR slice, one bit per cycle. It returns a per-requester done pulse with a word-equality flag. It sits between comparison clients and the team's XNOR primitive, so the gate can be time-shared instead of replicated W×N times.

## Interface
- `W`, default 8: operand width in bits; legal for W ≥ 1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req0`, `req1` in 1: request level; operands must be stable while high.
- `a0`, `b0`, `a1`, `b1` in W: operand pairs.
- `ack0`, `ack1` out 1: one-cycle pulse; operands were captured.
- `done0`, `done1` out 1: one-cycle pulse; result valid.
- `eq0`, `eq1` out 1: 1 when a == b. Registered and held until that requester's next done.
- `busy` out 1: high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when any req is high at an edge. At that edge:
  - the winner's a and b load into shift registers;
  - the bit counter clears;
  - the accumulator is set to 1;
  - `ackN` goes high for the following cycle.
- Arbitration:
  - If one request is pending, it is granted.
  - If both are pending, the requester not granted last is granted.
  - The last-grant register resets to "1", so `req0` wins the first tie.
- RUN, one cycle per bit:
  - x = ~(a_sr[0] ^ b_sr[0]);
  - acc &= x;
  - shift both registers right;
  - counter increments.
- RUN → DONE after exactly W bit cycles. No early exit on mismatch, so latency is constant.
- On entry to DONE, `eqN` is registered from acc and `doneN` is high for that one cycle.
- DONE → IDLE unconditionally.
- Requests are sampled only in IDLE. A req that stays high after its ack is treated as a new request at the next IDLE edge. A req dropped before ack is ignored, with no side effect.
- Outputs of the non-granted requester are untouched during the other's operation.

## Timing
- Let cycle c be the cycle in which `ackN` is high; this is also the first RUN cycle.
  - Bits 0..W-1 are processed in cycles c .. c+W-1.
  - `doneN` and the new `eqN` are visible in cycle c+W.
  - IDLE is in cycle c+W+1; the earliest next ack is cycle c+W+2.
- Throughput: one comparison per W+2 cycles.
- Grant latency: ack follows the first IDLE edge at which req is sampled high, i.e. one cycle.
- Reset values: every output is 0, state = IDLE, last-grant = 1, shift registers, accumulator and counter all 0.
- `rst_n` asserted mid-RUN or mid-DONE:
  - all outputs drop to 0 immediately (asynchronously);
  - the in-flight comparison is discarded and no done is issued;
  - the requester must re-issue after reset release.
- The counter is $clog2(W+1) bits wide and wraps only through reload on capture.

## Configuration
- `XNOR_CMP_SCHED_MATCHCNT_EN` defined:
  - adds ports `cnt0` and `cnt1`, out, $clog2(W+1) bits each;
  - an extra accumulator counts the bits with x = 1 (Hamming similarity);
  - the count is registered alongside `eqN` at DONE, held until the next done, reset to 0;
  - `eqN` = 1 exactly when `cntN` == W.
- Undefined: the ports and the counter logic are absent. Equality behaviour and timing are identical.

## Structure
- Package `xnor_cmp_pkg` holds:
  - state encodings IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10;
  - grant index constants GNT0 = 1'b0, GNT1 = 1'b1;
  - the counter-width function clog2.
- One sub-module, `xnor_bit_slice`:
  - 1-bit XNOR with AND-accumulate, plus the optional match-count increment;
  - inputs `a_bit`, `b_bit`, `acc_in`, `en`.
- Top level holds the FSM, arbiter, shift registers, counter and output registers.

## Test plan
All scenarios use W = 8.
- **Single match:** `req0` with `a0` = `b0` = 8'hA5 → `ack0` one cycle; `done0` 8 cycles later; `eq0` = 1; `cnt0` = 8.
- **One-bit mismatch:** `req1` with `a1` = 8'h0F, `b1` = 8'h0E → `eq1` = 0, `cnt1` = 7. `eq0` stays 1 from the previous test.
- **Tie after reset:** `req0` and `req1` asserted together → `ack0` first, `ack1` 10 cycles later. A second simultaneous pair → `ack1` first.
- **Reset mid-operation:** `rst_n` pulsed low in the 3rd RUN cycle → all outputs 0 at once, no done. After release, a reissued `req0` (8'h00 vs 8'hFF) gives `eq0` = 0, `cnt0` = 0.
- **Request edge cases:** `req0` held high across done → a second ack 2 cycles after done. `req1` dropped before grant → never acked. `busy` is high exactly from the ack cycle through the done cycle.
- **Width corner:** a W = 1 build, a = 1, b = 1 → done 1 cycle after ack, `eq` = 1, `cnt` = 1.

Source files
------------

// File: rtl/xnor_cmp_pkg.sv
// Shared definitions for the xnor_cmp_sched scheduler.
//   state_t     : FSM encoding (IDLE / RUN / DONE)
//   GNT0 / GNT1 : grant index constants for the two requesters
//   clog2       : ceiling log2, used to size the bit and match counters
package xnor_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic GNT0 = 1'b0;
  localparam logic GNT1 = 1'b1;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/xnor_bit_slice.sv
// One-bit XNOR equality slice with AND-accumulate.
// Optional feature macro: XNOR_CMP_SCHED_MATCHCNT_EN adds a match-count
// increment path (mcnt_in / mcnt_out).
// Ports:
//   a_bit, b_bit : current operand bits
//   acc_in       : running word-equality flag
//   en           : process this bit; when low the accumulators pass through
//   acc_out      : acc_in & xnor(a_bit, b_bit) when enabled
//   mcnt_in/out  : (optional) running count of matching bits
module xnor_bit_slice
  import xnor_cmp_pkg::*;
`ifdef XNOR_CMP_SCHED_MATCHCNT_EN
  #(parameter int CW = 4)
`endif
(
  input  logic          a_bit,
  input  logic          b_bit,
  input  logic          acc_in,
  input  logic          en,
`ifdef XNOR_CMP_SCHED_MATCHCNT_EN
  input  logic [CW-1:0] mcnt_in,
  output logic [CW-1:0] mcnt_out,
`endif
  output logic          acc_out
);

  logic x;

  assign x       = ~(a_bit ^ b_bit);
  assign acc_out = en ? (acc_in & x) : acc_in;

`ifdef XNOR_CMP_SCHED_MATCHCNT_EN
  assign mcnt_out = (en && x) ? (mcnt_in + CW'(1)) : mcnt_in;
`endif

endmodule

// File: rtl/xnor_cmp_sched.sv
// Two-requester round-robin scheduler sharing one bit-serial XNOR
// equality slice. The winner's operands are captured and streamed LSB-first,
// one bit per cycle; a done pulse with a word-equality flag follows after
// exactly W bit cycles.
// Optional feature macro: XNOR_CMP_SCHED_MATCHCNT_EN adds cnt0/cnt1
// (number of matching bits, registered with eqN).
//
// Handshake: reqN is a level held (with stable operands) until ackN pulses
// for one cycle; ackN marks the capture of aN/bN. Requests are sampled only
// in IDLE, so a req still high after its ack counts as a new request, and a
// req dropped before its ack leaves no trace. doneN pulses for one cycle with
// eqN (and cntN) valid; those stay held until that requester's next done.
//
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   req0/req1            : request levels
//   a0,b0 / a1,b1        : W-bit operand pairs
//   ack0/ack1            : capture pulse (first RUN cycle)
//   done0/done1          : result pulse
//   eq0/eq1              : held equality result
//   cnt0/cnt1            : (optional) held match count
//   busy                 : high in RUN and DONE
//   fsm_state            : current FSM state, for observation
module xnor_cmp_sched
  import xnor_cmp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0,
  input  logic                    req1,
  input  logic [W-1:0]            a0,
  input  logic [W-1:0]            b0,
  input  logic [W-1:0]            a1,
  input  logic [W-1:0]            b1,
  output logic                    ack0,
  output logic                    ack1,
  output logic                    done0,
  output logic                    done1,
  output logic                    eq0,
  output logic                    eq1,
  output logic                    busy,
`ifdef XNOR_CMP_SCHED_MATCHCNT_EN
  output logic [clog2(W+1)-1:0]   cnt0,
  output logic [clog2(W+1)-1:0]   cnt1,
`endif
  output logic [1:0]              fsm_state
);

  localparam int CW = clog2(W + 1);

  state_t          state, state_nxt;
  logic            last_gnt;   // requester granted most recently
  logic            gnt;        // requester owning the in-flight comparison
  logic            win;        // arbitration result in IDLE
  logic            any_req;
  logic            last_bit;
  logic            run_en;
  logic [W-1:0]    a_sr, b_sr;
  logic [CW-1:0]   bit_cnt;
  logic            acc, acc_nxt;
`ifdef XNOR_CMP_SCHED_MATCHCNT_EN
  logic [CW-1:0]   mcnt, mcnt_nxt;
`endif

  assign any_req   = req0 | req1;
  assign last_bit  = (bit_cnt == CW'(W - 1));
  assign run_en    = (state == RUN);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // Round-robin: on a tie the requester not granted last wins.
  always_comb begin
    win = GNT0;
    if (req0 && req1)  win = (last_gnt == GNT0) ? GNT1 : GNT0;
    else if (req1)     win = GNT1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  xnor_bit_slice
`ifdef XNOR_CMP_SCHED_MATCHCNT_EN
    #(.CW(CW))
`endif
    u_slice (
    .a_bit    (a_sr[0]),
    .b_bit    (b_sr[0]),
    .acc_in   (acc),
    .en       (run_en),
`ifdef XNOR_CMP_SCHED_MATCHCNT_EN
    .mcnt_in  (mcnt),
    .mcnt_out (mcnt_nxt),
`endif
    .acc_out  (acc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= GNT1;
      gnt      <= GNT0;
      a_sr     <= '0;
      b_sr     <= '0;
      bit_cnt  <= '0;
      acc      <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      eq0      <= 1'b0;
      eq1      <= 1'b0;
`ifdef XNOR_CMP_SCHED_MATCHCNT_EN
      mcnt     <= '0;
      cnt0     <= '0;
      cnt1     <= '0;
`endif
    end else begin
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            a_sr     <= (win == GNT1) ? a1 : a0;
            b_sr     <= (win == GNT1) ? b1 : b0;
            bit_cnt  <= '0;
            acc      <= 1'b1;
            gnt      <= win;
            last_gnt <= win;
            ack0     <= (win == GNT0);
            ack1     <= (win == GNT1);
`ifdef XNOR_CMP_SCHED_MATCHCNT_EN
            mcnt     <= '0;
`endif
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          acc     <= acc_nxt;
          bit_cnt <= bit_cnt + CW'(1);
`ifdef XNOR_CMP_SCHED_MATCHCNT_EN
          mcnt    <= mcnt_nxt;
`endif
          // The result registers take the post-last-bit accumulator so the
          // final bit is included without an extra cycle.
          if (last_bit) begin
            if (gnt == GNT1) begin
              done1 <= 1'b1;
              eq1   <= acc_nxt;
`ifdef XNOR_CMP_SCHED_MATCHCNT_EN
              cnt1  <= mcnt_nxt;
`endif
            end else begin
              done0 <= 1'b1;
              eq0   <= acc_nxt;
`ifdef XNOR_CMP_SCHED_MATCHCNT_EN
              cnt0  <= mcnt_nxt;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_cmp_sched.sv
// Directed bench for xnor_cmp_sched (W = 8) plus a W = 1 corner instance.
// Expected results are pushed as {id, eq, cnt[3:0]} into exp_q when a
// request is issued; the monitor pops one entry per done pulse.
module tb_xnor_cmp_sched;

  localparam int W  = 8;
  localparam int EW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic ack0, ack1, done0, done1, eq0, eq1, busy;
  logic [1:0] fsm_state;
`ifdef XNOR_CMP_SCHED_MATCHCNT_EN
  logic [3:0] cnt0, cnt1;
  logic       w1_cnt0, w1_cnt1;
`endif

  logic w1_req0 = 1'b0;
  logic w1_a0 = 1'b0, w1_b0 = 1'b0;
  logic w1_ack0, w1_ack1, w1_done0, w1_done1, w1_eq0, w1_eq1, w1_busy;
  logic [1:0] w1_state;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp, mon_got;

  always #5 clk = ~clk;

  xnor_cmp_sched #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .eq0(eq0), .eq1(eq1), .busy(busy),
`ifdef XNOR_CMP_SCHED_MATCHCNT_EN
    .cnt0(cnt0), .cnt1(cnt1),
`endif
    .fsm_state(fsm_state)
  );

  xnor_cmp_sched #(.W(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .req0(w1_req0), .req1(1'b0),
    .a0(w1_a0), .b0(w1_b0), .a1(1'b0), .b1(1'b0),
    .ack0(w1_ack0), .ack1(w1_ack1), .done0(w1_done0), .done1(w1_done1),
    .eq0(w1_eq0), .eq1(w1_eq1), .busy(w1_busy),
`ifdef XNOR_CMP_SCHED_MATCHCNT_EN
    .cnt0(w1_cnt0), .cnt1(w1_cnt1),
`endif
    .fsm_state(w1_state)
  );

  function automatic logic [EW-1:0] model(input logic id, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0] same;
    same = ~(a ^ b);
    return {id, (a == b), 4'($countones(same))};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns negedges counted until ackN is seen, or -1 on timeout.
  task automatic wait_ack(input logic id, input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(id ? ack1 : ack0) && cyc < limit);
    if (!(id ? ack1 : ack0)) cyc = -1;
  endtask

  task automatic wait_done(input logic id, input int limit, output int cyc,
                           output logic busy_ok);
    cyc = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      busy_ok &= busy;
    end while (!(id ? done1 : done0) && cyc < limit);
    if (!(id ? done1 : done0)) cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    w1_req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && (done0 || done1)) begin
      checks++;
      if (done0 && done1) begin
        errors++;
        $display("FAIL both_done: done0=%0d done1=%0d", done0, done1);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done0=%0d done1=%0d", done0, done1);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_got[5] = done1;
        mon_got[4] = done1 ? eq1 : eq0;
`ifdef XNOR_CMP_SCHED_MATCHCNT_EN
        mon_got[3:0] = done1 ? cnt1 : cnt0;
        if (mon_got != mon_exp) begin
`else
        mon_got[3:0] = 4'd0;
        if (mon_got[5:4] != mon_exp[5:4]) begin
`endif
          errors++;
          $display("FAIL result: got id/eq/cnt %0d/%0d/%0d expected %0d/%0d/%0d",
                   mon_got[5], mon_got[4], mon_got[3:0],
                   mon_exp[5], mon_exp[4], mon_exp[3:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic bok;
    logic seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {ack0, ack1, done0, done1, eq0, eq1, busy, fsm_state}, 0);
    rst_n = 1'b1;
    tick();

    // Single match on requester 0
    a0 = 8'hA5; b0 = 8'hA5;
    exp_q.push_back(model(1'b0, 8'hA5, 8'hA5));
    req0 = 1'b1;
    wait_ack(1'b0, 6, cyc);
    check("t1 ack0 latency", cyc, 2);
    req0 = 1'b0;
    check("t1 busy at ack", busy, 1);
    wait_done(1'b0, 20, cyc, bok);
    check("t1 done0 latency", cyc, 8);
    check("t1 busy through done", bok, 1);
    @(negedge clk);
    check("t1 busy after done", busy, 0);
    tick();

    // One-bit mismatch on requester 1; eq0 stays held
    a1 = 8'h0F; b1 = 8'h0E;
    exp_q.push_back(model(1'b1, 8'h0F, 8'h0E));
    req1 = 1'b1;
    wait_ack(1'b1, 6, cyc);
    check("t2 ack1 latency", cyc, 2);
    req1 = 1'b0;
    wait_done(1'b1, 20, cyc, bok);
    check("t2 done1 latency", cyc, 8);
    check("t2 eq0 held", eq0, 1);

    // Tie after reset: req0 wins; req0 kept high re-requests
    do_reset();
    tick();
    a0 = 8'h11; b0 = 8'h11; a1 = 8'h22; b1 = 8'h23;
    exp_q.push_back(model(1'b0, 8'h11, 8'h11));
    exp_q.push_back(model(1'b1, 8'h22, 8'h23));
    exp_q.push_back(model(1'b0, 8'h11, 8'h11));
    req0 = 1'b1; req1 = 1'b1;
    wait_ack(1'b0, 6, cyc);
    check("t3 tie ack0 first", cyc, 2);
    wait_ack(1'b1, 15, cyc);
    check("t3 ack1 after ack0", cyc, 10);
    req1 = 1'b0;
    wait_ack(1'b0, 15, cyc);
    check("t3 held req0 re-ack", cyc, 10);
    req0 = 1'b0;
    wait_done(1'b0, 20, cyc, bok);
    check("t3 done0 latency", cyc, 8);
    tick();
    // Fresh simultaneous pair: req0 was granted last, so req1 wins
    a0 = 8'h3C; b0 = 8'h3C; a1 = 8'hF0; b1 = 8'h0F;
    exp_q.push_back(model(1'b1, 8'hF0, 8'h0F));
    exp_q.push_back(model(1'b0, 8'h3C, 8'h3C));
    req0 = 1'b1; req1 = 1'b1;
    wait_ack(1'b1, 6, cyc);
    check("t3 second tie ack1 first", cyc, 2);
    req1 = 1'b0;
    wait_ack(1'b0, 15, cyc);
    check("t3 second tie ack0 next", cyc, 10);
    req0 = 1'b0;
    wait_done(1'b0, 20, cyc, bok);
    check("t3 second done0 latency", cyc, 8);
    tick();

    // Reset mid-operation: async clear, no done
    a0 = 8'h55; b0 = 8'h55;
    req0 = 1'b1;
    wait_ack(1'b0, 6, cyc);
    check("t4 ack0 latency", cyc, 2);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4 async reset outputs",
          {ack0, ack1, done0, done1, eq0, eq1, busy, fsm_state}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    tick();
    a0 = 8'h00; b0 = 8'hFF;
    exp_q.push_back(model(1'b0, 8'h00, 8'hFF));
    req0 = 1'b1;
    wait_ack(1'b0, 6, cyc);
    check("t4 reissue ack0", cyc, 2);
    req0 = 1'b0;
    wait_done(1'b0, 20, cyc, bok);
    check("t4 reissue done0", cyc, 8);
    tick();

    // req1 dropped before grant is never acked
    a0 = 8'h5A; b0 = 8'h5B; a1 = 8'h77; b1 = 8'h77;
    exp_q.push_back(model(1'b0, 8'h5A, 8'h5B));
    req0 = 1'b1;
    wait_ack(1'b0, 6, cyc);
    check("t5 ack0 latency", cyc, 2);
    req0 = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    req1 = 1'b1;
    repeat (2) @(negedge clk);
    req1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      seen |= ack1;
    end
    check("t5 dropped req1 never acked", seen, 0);
    tick();

    // Width corner, W = 1
    w1_a0 = 1'b1; w1_b0 = 1'b1;
    w1_req0 = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!w1_ack0 && cyc < 6);
    check("w1 ack0 latency", cyc, 2);
    w1_req0 = 1'b0;
    @(negedge clk);
    check("w1 done0 one cycle after ack", w1_done0, 1);
    check("w1 eq0", w1_eq0, 1);
`ifdef XNOR_CMP_SCHED_MATCHCNT_EN
    check("w1 cnt0", w1_cnt0, 1);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
